// File: rtl/gs_pkg.sv
// Shared types for the execute-stage ALU arbiter: ALUCtrl codes, response entry, queue states.
package gs_pkg;

    typedef enum logic [3:0] {
        ALU_PLUS  = 4'd0,
        ALU_MINUS = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_BEQ   = 4'd10,
        ALU_BNE   = 4'd11,
        ALU_BLT   = 4'd12,
        ALU_BGE   = 4'd13,
        ALU_BLTU  = 4'd14,
        ALU_BGEU  = 4'd15
    } alu_op_e;

    // Sized for the largest supported requester count (4); narrower tops truncate.
    localparam int RSP_ID_W = 2;

    typedef struct packed {
        logic [RSP_ID_W-1:0] id;
        logic [31:0]         data;
        logic                br;
    } alu_rsp_t;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_e;

endpackage

// File: rtl/gs_rr_arb.sv
// Round-robin arbiter: one-hot grant in the same cycle, pointer moves past the winner on grant.
// No grant while en is low; pointer only advances on an actual grant.
module gs_rr_arb #(
    parameter  int NREQ = 2,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_vld
);

    logic [ID_W-1:0] ptr;
    int              idx;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (en && !gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
        gnt = gnt_vld ? (NREQ'(1) << gnt_id) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (gnt_vld) begin
            ptr <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
    end

endmodule

// File: rtl/gs_alu_arb.sv
// Shares one GS_ALU among NREQ requesters; result reaches rsp_valid 1 cycle after the grant.
// req_ready comes only from registered queue state: a FULL queue blocks issue even if it pops.
module gs_alu_arb
    import gs_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0][3:0]   req_op,
    input  logic [NREQ-1:0][31:0]  req_rs1,
    input  logic [NREQ-1:0][31:0]  req_rs2,
    output logic [31:0]            alu_rs1,
    output logic [31:0]            alu_rs2,
    output logic [3:0]             alu_ctrl,
    input  logic [31:0]            alu_data,
    input  logic                   alu_br,
    input  logic                   flush,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_data,
    output logic                   rsp_br
);

    q_state_e        q_state;
    alu_rsp_t        q_head;
    alu_rsp_t        q_tail;
    alu_rsp_t        new_ent;
    logic            issue_en;
    logic            push;
    logic            pop;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_vld;

    // Gating with rst keeps the ALU idle and req_ready low for the whole reset window.
    assign issue_en = rst && (q_state != Q_FULL) && !flush;

    gs_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .en      (issue_en),
        .gnt     (req_ready),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    assign alu_rs1  = gnt_vld ? req_rs1[gnt_id] : 32'd0;
    assign alu_rs2  = gnt_vld ? req_rs2[gnt_id] : 32'd0;
    assign alu_ctrl = gnt_vld ? req_op[gnt_id]  : 4'd0;

    assign new_ent.id   = RSP_ID_W'(gnt_id);
    assign new_ent.data = alu_data;
    assign new_ent.br   = alu_br;

    assign push = gnt_vld;
    assign pop  = rsp_valid && rsp_ready;

    // Head-ordered two-entry queue: q_head is always the oldest entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_state <= Q_EMPTY;
            q_head  <= '0;
            q_tail  <= '0;
        end else if (flush) begin
            q_state <= Q_EMPTY;
        end else begin
            case (q_state)
                Q_EMPTY: begin
                    if (push) begin
                        q_head  <= new_ent;
                        q_state <= Q_ONE;
                    end
                end
                Q_ONE: begin
                    if (push && pop) begin
                        q_head <= new_ent;
                    end else if (push) begin
                        q_tail  <= new_ent;
                        q_state <= Q_FULL;
                    end else if (pop) begin
                        q_state <= Q_EMPTY;
                    end
                end
                Q_FULL: begin
                    if (pop) begin
                        q_head <= q_tail;
                        if (push) begin
                            q_tail <= new_ent;
                        end else begin
                            q_state <= Q_ONE;
                        end
                    end
                end
                default: q_state <= Q_EMPTY;
            endcase
        end
    end

    assign rsp_valid = (q_state != Q_EMPTY);
    assign rsp_id    = ID_W'(q_head.id);
    assign rsp_data  = q_head.data;
    assign rsp_br    = q_head.br;

endmodule

// File: tb/tb_gs_alu_arb.sv
// Directed bench for gs_alu_arb with a small behavioural GS_ALU closing the loop.
module tb_gs_alu_arb;
    import gs_pkg::*;

    localparam int NREQ = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][3:0]  req_op;
    logic [NREQ-1:0][31:0] req_rs1;
    logic [NREQ-1:0][31:0] req_rs2;
    logic [31:0]           alu_rs1;
    logic [31:0]           alu_rs2;
    logic [3:0]            alu_ctrl;
    logic [31:0]           alu_data;
    logic                  alu_br;
    logic                  flush;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [31:0]           rsp_data;
    logic                  rsp_br;

    int checks = 0;
    int passed = 0;

    gs_alu_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .alu_rs1   (alu_rs1),
        .alu_rs2   (alu_rs2),
        .alu_ctrl  (alu_ctrl),
        .alu_data  (alu_data),
        .alu_br    (alu_br),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_br    (rsp_br)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_data = 32'd0;
        alu_br   = 1'b0;
        case (alu_op_e'(alu_ctrl))
            ALU_PLUS:  alu_data = alu_rs1 + alu_rs2;
            ALU_MINUS: alu_data = alu_rs1 - alu_rs2;
            ALU_BEQ:   alu_br   = (alu_rs1 == alu_rs2);
            ALU_BLTU:  alu_br   = (alu_rs1 < alu_rs2);
            default:   ;
        endcase
    end

    task automatic set_default_ops();
        req_op[0] = ALU_PLUS;  req_rs1[0] = 32'd10; req_rs2[0] = 32'd1;
        req_op[1] = ALU_MINUS; req_rs1[1] = 32'd50; req_rs2[1] = 32'd8;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
        req_valid = 2'b11;
        set_default_ops();
        #1 rst = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else passed++;
        checks++; if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id: got %b expected 0", rsp_id); else passed++;
        checks++; if (rsp_data !== 32'd0) $display("FAIL reset_rsp_data: got %0h expected 0", rsp_data); else passed++;
        checks++; if (rsp_br !== 1'b0) $display("FAIL reset_rsp_br: got %b expected 0", rsp_br); else passed++;
        checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b expected 00", req_ready); else passed++;
        checks++; if (alu_rs1 !== 32'd0 || alu_rs2 !== 32'd0 || alu_ctrl !== 4'd0)
            $display("FAIL reset_alu: got %0h/%0h/%0h expected 0/0/0", alu_rs1, alu_rs2, alu_ctrl); else passed++;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_held_rsp_valid: got %b expected 0", rsp_valid); else passed++;
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1 rst = 1'b1;
    endtask

    task automatic test_single();
        req_valid = 2'b01; rsp_ready = 1'b1;
        req_op[0] = ALU_PLUS; req_rs1[0] = 32'd5; req_rs2[0] = 32'd7;
        #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL single_req_ready: got %b expected 01", req_ready); else passed++;
        checks++; if (alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7 || alu_ctrl !== ALU_PLUS)
            $display("FAIL single_alu_drive: got %0d/%0d/%0d expected 5/7/0", alu_rs1, alu_rs2, alu_ctrl); else passed++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); else passed++;
        checks++; if (rsp_id !== 1'b0) $display("FAIL single_rsp_id: got %0d expected 0", rsp_id); else passed++;
        checks++; if (rsp_data !== 32'd12) $display("FAIL single_rsp_data: got %0d expected 12", rsp_data); else passed++;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL single_drain: got %b expected 0", rsp_valid); else passed++;
    endtask

    task automatic test_alternate();
        logic [1:0]  exp_gnt;
        logic [31:0] exp_data;
        set_default_ops();
        req_valid = 2'b11; rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_gnt  = (k % 2 == 1) ? 2'b10 : 2'b01;
            exp_data = (k % 2 == 1) ? 32'd42 : 32'd11;
            #1;
            checks++; if (req_ready !== exp_gnt) $display("FAIL alt_req_ready[%0d]: got %b expected %b", k, req_ready, exp_gnt); else passed++;
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_gnt[1] || rsp_data !== exp_data)
                $display("FAIL alt_rsp[%0d]: got v=%b id=%0d d=%0d expected v=1 id=%0d d=%0d",
                         k, rsp_valid, rsp_id, rsp_data, exp_gnt[1], exp_data); else passed++;
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL alt_drain: got %b expected 0", rsp_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        set_default_ops();
        req_valid = 2'b11; rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL bp_gnt0: got %b expected 01", req_ready); else passed++;
        @(posedge clk); #1;
        checks++; if (req_ready !== 2'b10) $display("FAIL bp_gnt1: got %b expected 10", req_ready); else passed++;
        @(posedge clk); #1;
        checks++; if (req_ready !== 2'b00) $display("FAIL bp_full_block: got %b expected 00", req_ready); else passed++;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd11)
            $display("FAIL bp_hold: got v=%b id=%0d d=%0d expected v=1 id=0 d=11", rsp_valid, rsp_id, rsp_data); else passed++;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b00) $display("FAIL bp_full_pop_block: got %b expected 00", req_ready); else passed++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd42)
            $display("FAIL bp_drain2: got v=%b id=%0d d=%0d expected v=1 id=1 d=42", rsp_valid, rsp_id, rsp_data); else passed++;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_empty: got %b expected 0", rsp_valid); else passed++;
    endtask

    task automatic test_branch();
        req_valid = 2'b10; rsp_ready = 1'b1;
        req_op[1] = ALU_BEQ; req_rs1[1] = 32'h1234; req_rs2[1] = 32'h1234;
        #1;
        checks++; if (req_ready !== 2'b10) $display("FAIL br_gnt: got %b expected 10", req_ready); else passed++;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_br !== 1'b1)
            $display("FAIL br_beq: got v=%b id=%0d br=%b expected v=1 id=1 br=1", rsp_valid, rsp_id, rsp_br); else passed++;
        req_op[1] = ALU_BLTU; req_rs1[1] = 32'hFFFF_FFFF; req_rs2[1] = 32'd1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_br !== 1'b0)
            $display("FAIL br_bltu: got v=%b id=%0d br=%b expected v=1 id=1 br=0", rsp_valid, rsp_id, rsp_br); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        set_default_ops();
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        @(posedge clk); #1;
        req_valid = 2'b01;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || req_ready !== 2'b00)
            $display("FAIL flush_prefill: got v=%b rdy=%b expected v=1 rdy=00", rsp_valid, req_ready); else passed++;
        req_valid = 2'b11; flush = 1'b1; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b00 || alu_ctrl !== 4'd0 || alu_rs1 !== 32'd0)
            $display("FAIL flush_no_grant: got rdy=%b ctrl=%0d rs1=%0d expected 00/0/0", req_ready, alu_ctrl, alu_rs1); else passed++;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL flush_empty: got %b expected 0", rsp_valid); else passed++;
        #1;
        checks++; if (req_ready !== 2'b10) $display("FAIL flush_ptr_kept: got %b expected 10", req_ready); else passed++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd42)
            $display("FAIL flush_after: got v=%b id=%0d d=%0d expected v=1 id=1 d=42", rsp_valid, rsp_id, rsp_data); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        set_default_ops();
        req_valid = 2'b11; rsp_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1) $display("FAIL areset_pre: got %b expected 1", rsp_valid); else passed++;
        #2 rst = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b00)
            $display("FAIL areset_immediate: got v=%b rdy=%b expected 0/00", rsp_valid, req_ready); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL areset_first_gnt: got %b expected 01", req_ready); else passed++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd11)
            $display("FAIL areset_first_rsp: got v=%b id=%0d d=%0d expected v=1 id=0 d=11", rsp_valid, rsp_id, rsp_data); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        do_reset();
        test_alternate();
        test_back_to_back();
        test_branch();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
